// File: rtl/dbg_bus_master_if.sv
// Signal bundle for dbg_bus_master: byte-stream command/response channels
// plus the peripheral write/read port.
interface dbg_bus_master_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        wr_en_o;
   logic [31:0] addr_o;
   logic [31:0] data_o;
   logic [31:0] data_i;
   logic        busy_o;

   modport master (
      input  rx_data_i, rx_valid_i, tx_ready_i, data_i,
      output rx_ready_o, tx_data_o, tx_valid_o, wr_en_o, addr_o, data_o, busy_o
   );

   modport slave (
      output rx_data_i, rx_valid_i, tx_ready_i, data_i,
      input  rx_ready_o, tx_data_o, tx_valid_o, wr_en_o, addr_o, data_o, busy_o
   );
endinterface

// File: rtl/dbg_bus_master.sv
// Byte-stream debug bus initiator: 'W' addr[4] data[4] writes, 'R' addr[4] reads,
// with a 1- or 4-byte response stream and an inter-byte timeout.
module dbg_bus_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   dbg_bus_master_if.master bus
);
   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ, RESP} state_t;

   localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

   state_t      state_reg, state_next;
   logic        is_write_reg, is_write_next;
   logic [1:0]  byte_cnt_reg, byte_cnt_next;
   logic [31:0] addr_reg, addr_next;
   logic [31:0] data_reg, data_next;
   logic [31:0] resp_reg, resp_next;
   logic [2:0]  resp_cnt_reg, resp_cnt_next;
   logic [31:0] tmo_cnt_reg, tmo_cnt_next;

   logic rx_fire;
   logic tx_fire;
   logic tmo_hit;

   // All outputs decode directly from async-reset registers, so reset takes effect without a clock.
   assign bus.rx_ready_o = (state_reg == IDLE) || (state_reg == ADDR) || (state_reg == DATA);
   assign bus.tx_valid_o = (state_reg == RESP);
   assign bus.tx_data_o  = resp_reg[31:24];
   assign bus.wr_en_o    = (state_reg == WRITE);
   assign bus.addr_o     = addr_reg;
   assign bus.data_o     = data_reg;
   assign bus.busy_o     = (state_reg != IDLE);

   assign rx_fire = bus.rx_valid_i && bus.rx_ready_o;
   assign tx_fire = bus.tx_valid_o && bus.tx_ready_i;
   assign tmo_hit = TMO_EN && (tmo_cnt_reg == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         is_write_reg <= 1'b0;
         byte_cnt_reg <= '0;
         addr_reg     <= '0;
         data_reg     <= '0;
         resp_reg     <= '0;
         resp_cnt_reg <= '0;
         tmo_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         is_write_reg <= is_write_next;
         byte_cnt_reg <= byte_cnt_next;
         addr_reg     <= addr_next;
         data_reg     <= data_next;
         resp_reg     <= resp_next;
         resp_cnt_reg <= resp_cnt_next;
         tmo_cnt_reg  <= tmo_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      is_write_next = is_write_reg;
      byte_cnt_next = byte_cnt_reg;
      addr_next     = addr_reg;
      data_next     = data_reg;
      resp_next     = resp_reg;
      resp_cnt_next = resp_cnt_reg;
      tmo_cnt_next  = tmo_cnt_reg;

      case (state_reg)
         IDLE: begin
            byte_cnt_next = '0;
            tmo_cnt_next  = '0;
            if (rx_fire) begin
               if (bus.rx_data_i == 8'h57) begin
                  is_write_next = 1'b1;
                  state_next    = ADDR;
               end else if (bus.rx_data_i == 8'h52) begin
                  is_write_next = 1'b0;
                  state_next    = ADDR;
               end else begin
                  resp_next     = {8'h45, 24'h0};
                  resp_cnt_next = 3'd1;
                  state_next    = RESP;
               end
            end
         end
         ADDR: begin
            if (rx_fire) begin
               tmo_cnt_next  = '0;
               addr_next     = {addr_reg[23:0], bus.rx_data_i};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  byte_cnt_next = '0;
                  state_next    = is_write_reg ? DATA : READ;
               end
            end else if (tmo_hit) begin
               tmo_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 32'd1;
            end
         end
         DATA: begin
            if (rx_fire) begin
               tmo_cnt_next  = '0;
               data_next     = {data_reg[23:0], bus.rx_data_i};
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
                  byte_cnt_next = '0;
                  state_next    = WRITE;
               end
            end else if (tmo_hit) begin
               tmo_cnt_next = '0;
               state_next   = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 32'd1;
            end
         end
         WRITE: begin
            resp_next     = {8'h4B, 24'h0};
            resp_cnt_next = 3'd1;
            state_next    = RESP;
         end
         READ: begin
            resp_next     = bus.data_i;
            resp_cnt_next = 3'd4;
            state_next    = RESP;
         end
         RESP: begin
            if (tx_fire) begin
               resp_next     = {resp_reg[23:0], 8'h00};
               resp_cnt_next = resp_cnt_reg - 3'd1;
               if (resp_cnt_reg == 3'd1) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed bench for dbg_bus_master: scoreboard queues for writes and tx bytes,
// immediate-assertion checks, timeout configured to 16 cycles.
module tb_dbg_bus_master;
   logic clk;
   logic rst_n;

   dbg_bus_master_if bus();

   dbg_bus_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_tx[$];
   logic [63:0] exp_wr[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Peripheral read model: address 4 returns a known word, others a pattern of the address.
   function automatic logic [31:0] periph(input logic [31:0] a);
      return (a == 32'h4) ? 32'h12345678 : (a ^ 32'hA5A5A5A5);
   endfunction

   assign bus.data_i = periph(bus.addr_o);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      @(negedge clk);
      while (!bus.rx_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rx_accept", {31'b0, bus.rx_ready_o}, 32'd1);
      @(posedge clk);
      #1;
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   task automatic push_read(input logic [31:0] a);
      logic [31:0] d;
      d = periph(a);
      exp_tx.push_back(d[31:24]);
      exp_tx.push_back(d[23:16]);
      exp_tx.push_back(d[15:8]);
      exp_tx.push_back(d[7:0]);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", {31'b0, bus.busy_o}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"},    {31'b0, bus.wr_en_o},    32'd0);
      check({tag, "_addr"},     bus.addr_o,              32'd0);
      check({tag, "_data"},     bus.data_o,              32'd0);
      check({tag, "_tx_valid"}, {31'b0, bus.tx_valid_o}, 32'd0);
      check({tag, "_tx_data"},  {24'b0, bus.tx_data_o},  32'd0);
      check({tag, "_busy"},     {31'b0, bus.busy_o},     32'd0);
      check({tag, "_rx_ready"}, {31'b0, bus.rx_ready_o}, 32'd1);
   endtask

   // Monitor: every write strobe and tx handshake is matched against the scoreboard.
   logic [63:0] mon_wr;
   logic [7:0]  mon_tx;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.wr_en_o) begin
            $display("wr addr=%h data=%h", bus.addr_o, bus.data_o);
            if (exp_wr.size() == 0) begin
               check("wr_unexpected", {31'b0, bus.wr_en_o}, 32'd0);
            end else begin
               mon_wr = exp_wr.pop_front();
               check("wr_addr", bus.addr_o, mon_wr[63:32]);
               check("wr_data", bus.data_o, mon_wr[31:0]);
            end
         end
         if (bus.tx_valid_o && bus.tx_ready_i) begin
            $display("tx byte=%h", bus.tx_data_o);
            if (exp_tx.size() == 0) begin
               check("tx_unexpected", {31'b0, bus.tx_valid_o}, 32'd0);
            end else begin
               mon_tx = exp_tx.pop_front();
               check("tx_byte", {24'b0, bus.tx_data_o}, {24'b0, mon_tx});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b1;
      bus.rx_data_i  = 8'h00;
      bus.rx_valid_i = 1'b0;
      bus.tx_ready_i = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Write 0xDEADBEEF to address 4
      exp_wr.push_back({32'h4, 32'hDEADBEEF});
      exp_tx.push_back(8'h4B);
      send_byte(8'h57);
      send_word(32'h4);
      send_word(32'hDEADBEEF);
      check("wr_latency", {31'b0, bus.wr_en_o}, 32'd1);
      check("wr_no_tx_yet", {31'b0, bus.tx_valid_o}, 32'd0);
      check("wr_rx_blocked", {31'b0, bus.rx_ready_o}, 32'd0);
      @(posedge clk); #1;
      check("wr_resp_valid", {31'b0, bus.tx_valid_o}, 32'd1);
      check("wr_resp_byte", {24'b0, bus.tx_data_o}, 32'h4B);
      check("wr_pulse_end", {31'b0, bus.wr_en_o}, 32'd0);
      wait_idle();

      // Read address 4
      push_read(32'h4);
      send_byte(8'h52);
      send_word(32'h4);
      check("rd_busy", {31'b0, bus.busy_o}, 32'd1);
      check("rd_rx_blocked", {31'b0, bus.rx_ready_o}, 32'd0);
      check("rd_no_tx_yet", {31'b0, bus.tx_valid_o}, 32'd0);
      @(posedge clk); #1;
      check("rd_resp_valid", {31'b0, bus.tx_valid_o}, 32'd1);
      check("rd_first_byte", {24'b0, bus.tx_data_o}, 32'h12);
      wait_idle();

      // Unknown command byte
      exp_tx.push_back(8'h45);
      send_byte(8'h00);
      wait_idle();
      check("err_addr_kept", bus.addr_o, 32'h4);
      check("err_data_kept", bus.data_o, 32'hDEADBEEF);

      // Read with the sink stalled for 10 cycles
      bus.tx_ready_i = 1'b0;
      push_read(32'h100);
      send_byte(8'h52);
      send_word(32'h100);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_tx_valid", {31'b0, bus.tx_valid_o}, 32'd1);
         check("bp_tx_hold", {24'b0, bus.tx_data_o}, 32'hA5);
         check("bp_rx_blocked", {31'b0, bus.rx_ready_o}, 32'd0);
      end
      @(posedge clk); #1;
      bus.tx_ready_i = 1'b1;
      wait_idle();
      check("bp_drained", 32'(exp_tx.size()), 32'd0);

      // Partial write abandoned: timeout after 16 idle cycles
      send_byte(8'h57);
      send_byte(8'h00);
      repeat (15) @(posedge clk);
      #1;
      check("tmo_not_yet", {31'b0, bus.busy_o}, 32'd1);
      @(posedge clk); #1;
      check("tmo_busy", {31'b0, bus.busy_o}, 32'd0);
      check("tmo_rx_ready", {31'b0, bus.rx_ready_o}, 32'd1);
      check("tmo_no_tx", {31'b0, bus.tx_valid_o}, 32'd0);
      check("tmo_addr_kept", bus.addr_o, 32'h00010000);
      check("tmo_data_kept", bus.data_o, 32'hDEADBEEF);
      push_read(32'h4);
      send_byte(8'h52);
      send_word(32'h4);
      wait_idle();

      // Reset after the 6th byte of a write
      send_byte(8'h57);
      send_word(32'h8);
      send_byte(8'h11);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_wr.push_back({32'h20, 32'hCAFEF00D});
      exp_tx.push_back(8'h4B);
      send_byte(8'h57);
      send_word(32'h20);
      send_word(32'hCAFEF00D);
      wait_idle();
      check("post_rst_addr", bus.addr_o, 32'h20);
      check("post_rst_data", bus.data_o, 32'hCAFEF00D);

      check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 The block SHALL have this parameter: TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles while a command is partial; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 rx_data_i  input  8  command byte from the byte source.
REQ-005 rx_valid_i  input  1  rx_data_i is valid.
REQ-006 rx_ready_o  output  1  block accepts a byte; a byte transfers when rx_valid_i and rx_ready_o are both 1 at a clk edge.
REQ-007 tx_data_o  output  8  response byte.
REQ-008 tx_valid_o  output  1  tx_data_o is valid.
REQ-009 tx_ready_i  input  1  sink accepts a byte; a byte transfers when tx_valid_i and tx_ready_i are both 1 at a clk edge.
REQ-010 wr_en_o  output  1  peripheral write strobe, one cycle per write.
REQ-011 addr_o  output  32  peripheral address.
REQ-012 data_o  output  32  peripheral write data.
REQ-013 data_i  input  32  peripheral read data, combinational function of addr_o.
REQ-014 busy_o  output  1  1 whenever state is not IDLE.

Function
REQ-015 The block SHALL be a bus initiator driving the peripheral write/read port from a byte-stream command protocol.
REQ-016 Commands: 0x57 ('W') + 4 address bytes + 4 data bytes; 0x52 ('R') + 4 address bytes; all multi-byte fields MSB first.
REQ-017 States: IDLE, ADDR, DATA, WRITE, READ, RESP.
REQ-018 rx_ready_o SHALL be 1 in IDLE, ADDR and DATA and 0 in WRITE, READ and RESP.
REQ-019 IDLE: on an accepted byte, 0x57 sets the write flag and goes to ADDR, 0x52 clears it and goes to ADDR, and any other value loads response 0xFF-free single byte 0x45 ('E') and goes to RESP.
REQ-020 ADDR: each accepted byte shifts into addr_o from the LSB end (addr_o <= {addr_o[23:0], byte}); after the 4th byte, go to DATA if the write flag is set, else READ.
REQ-021 DATA: each accepted byte shifts into data_o the same way; after the 4th byte, go to WRITE.
REQ-022 A 2-bit byte counter SHALL count accepted bytes in ADDR and DATA, clearing on each state entry.
REQ-023 WRITE: wr_en_o=1 for exactly this one cycle with the final addr_o/data_o, then load 1-byte response 0x4B ('K') and go to RESP.
REQ-024 wr_en_o SHALL be 0 in every other state.
REQ-025 READ: lasts one cycle; capture data_i into the 32-bit response register, set count 4, go to RESP.
REQ-026 addr_o SHALL be stable from the end of ADDR through READ.
REQ-027 RESP: tx_valid_o=1 and tx_data_o=response[31:24]; a 1-byte response is loaded into response[31:24].
REQ-028 On each tx handshake, response shifts left 8 and the count decrements; after the last byte, go to IDLE with tx_valid_o=0.
REQ-029 While tx_ready_i=0, tx_valid_o and tx_data_o SHALL hold.
REQ-030 Latency: wr_en_o is asserted in the cycle after the 4th data byte is accepted, and tx_valid_o in the cycle after that; read capture is in the cycle after the 4th address byte, and tx_valid_o in the next cycle.
REQ-031 Timeout: in ADDR/DATA, a counter clears on each accepted byte and increments otherwise; on reaching TIMEOUT_CYCLES the block returns to IDLE with no bus access and no response.
REQ-032 addr_o and data_o SHALL keep their last values after a timeout or error.
REQ-033 Bytes presented while rx_ready_o=0 SHALL be neither consumed nor lost.

Reset
REQ-034 rst_n low SHALL force immediately, regardless of clk: state IDLE, wr_en_o=0, addr_o=0, data_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, rx_ready_o=1, and clear all counters and the response register.
REQ-035 Reset mid-command SHALL discard the partial command with no wr_en_o pulse.

Verification
REQ-036 Rx 57 00 00 00 04 DE AD BE EF -> exactly one cycle wr_en_o=1 with addr_o=0x00000004, data_o=0xDEADBEEF; then tx 4B.
REQ-037 Rx 52 00 00 00 04 with data_i=0x12345678 at addr 4 -> tx 12 34 56 78 in order; wr_en_o never 1.
REQ-038 Rx 00 -> tx 45, back to IDLE, wr_en_o never 1, addr_o unchanged.
REQ-039 tx_ready_i=0 for 10 cycles during a read response -> tx_data_o stable, no byte dropped or repeated, rx_ready_o=0 throughout.
REQ-040 TIMEOUT_CYCLES=16: rx 57 00 then 16 idle cycles -> IDLE, busy_o=0, no wr_en_o, no tx; a following read completes normally.
REQ-041 rst_n low after the 6th byte of a write -> outputs at reset values without a clk edge; a following full write succeeds.
